// File: rtl/dii_package.sv
// Shared DII ring definitions: flit layout plus register-access type and sub-type codes,
// used by both the initiator (osd_reg_master) and the target-side regaccess logic.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    localparam logic [1:0] TYPE_REG = 2'b00;

    localparam logic [3:0] REQ_READ_REG_16          = 4'h0;
    localparam logic [3:0] REQ_WRITE_REG_16         = 4'h4;
    localparam logic [3:0] RESP_READ_REG_SUCCESS_16 = 4'h8;
    localparam logic [3:0] RESP_READ_REG_ERROR      = 4'hc;
    localparam logic [3:0] RESP_WRITE_REG_SUCCESS   = 4'he;
    localparam logic [3:0] RESP_WRITE_REG_ERROR     = 4'hf;

    // Flags word of a register-access packet: {type, sub, 10'h0}.
    function automatic logic [15:0] reg_flags(input logic [3:0] sub);
        return {TYPE_REG, sub, 10'h0};
    endfunction

endpackage

// File: rtl/osd_reg_master_if.sv
// Local request/response port of osd_reg_master, with the FSM state exposed for observation.
interface osd_reg_master_if;

    // Both channels are valid/ready: a transfer happens on a clock edge where valid & ready are
    // both high; the sender holds valid and its payload stable until that edge.
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dest;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    logic [3:0]  dbg_state;

    modport master (
        output req_valid, req_dest, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, dbg_state
    );

    modport slave (
        input  req_valid, req_dest, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, dbg_state
    );

endinterface

// File: rtl/osd_reg_master.sv
// DII register-access initiator: sends one 16-bit read/write request packet on the ring and
// returns the matching response (or an error on timeout) on the local response port.
module osd_reg_master
    import dii_package::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             id,
    osd_reg_master_if.slave         bus,
    output dii_flit                 debug_out,
    input  logic                    debug_out_ready,
    input  dii_flit                 debug_in,
    output logic                    debug_in_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, TX_DEST, TX_SRC, TX_FLAGS, TX_ADDR, TX_DATA,
        RX_DEST, RX_SRC, RX_FLAGS, RX_DATA, DROP, RESP
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      dest_q, addr_q, wdata_q, rdata_q, rdata_nxt;
    logic             write_q, err_q, err_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             in_rx, timeout;
    logic [1:0]       flit_type;
    logic [3:0]       flit_sub;

    assign in_rx     = state inside {RX_DEST, RX_SRC, RX_FLAGS, RX_DATA, DROP};
    assign timeout   = in_rx && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign flit_type = debug_in.data[15:14];
    assign flit_sub  = debug_in.data[13:10];

    // Incoming flits are always consumed; outside RX they are simply discarded.
    assign debug_in_ready = 1'b1;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.dbg_state  = state;

    always_comb begin
        state_nxt = state;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        debug_out = '0;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = TX_DEST;
            TX_DEST: begin
                debug_out.valid = 1'b1;
                debug_out.data  = dest_q;
                if (debug_out_ready) state_nxt = TX_SRC;
            end
            TX_SRC: begin
                debug_out.valid = 1'b1;
                debug_out.data  = id;
                if (debug_out_ready) state_nxt = TX_FLAGS;
            end
            TX_FLAGS: begin
                debug_out.valid = 1'b1;
                debug_out.data  = reg_flags(write_q ? REQ_WRITE_REG_16 : REQ_READ_REG_16);
                if (debug_out_ready) state_nxt = TX_ADDR;
            end
            TX_ADDR: begin
                debug_out.valid = 1'b1;
                debug_out.last  = !write_q;
                debug_out.data  = addr_q;
                if (debug_out_ready) state_nxt = write_q ? TX_DATA : RX_DEST;
            end
            TX_DATA: begin
                debug_out.valid = 1'b1;
                debug_out.last  = 1'b1;
                debug_out.data  = wdata_q;
                if (debug_out_ready) state_nxt = RX_DEST;
            end
            // Any header mismatch or premature last resynchronises on the packet boundary.
            RX_DEST: if (debug_in.valid) begin
                if (debug_in.data == id && !debug_in.last) state_nxt = RX_SRC;
                else state_nxt = debug_in.last ? RX_DEST : DROP;
            end
            RX_SRC: if (debug_in.valid) begin
                if (debug_in.data == dest_q && !debug_in.last) state_nxt = RX_FLAGS;
                else state_nxt = debug_in.last ? RX_DEST : DROP;
            end
            RX_FLAGS: if (debug_in.valid) begin
                if (flit_type == TYPE_REG && !write_q && flit_sub == RESP_READ_REG_SUCCESS_16
                    && !debug_in.last) begin
                    state_nxt = RX_DATA;
                end else if (flit_type == TYPE_REG && debug_in.last &&
                             ((!write_q && flit_sub == RESP_READ_REG_ERROR) ||
                              (write_q && (flit_sub == RESP_WRITE_REG_SUCCESS ||
                                           flit_sub == RESP_WRITE_REG_ERROR)))) begin
                    state_nxt = RESP;
                    rdata_nxt = '0;
                    err_nxt   = (flit_sub != RESP_WRITE_REG_SUCCESS);
                end else begin
                    state_nxt = debug_in.last ? RX_DEST : DROP;
                end
            end
            RX_DATA: if (debug_in.valid) begin
                if (debug_in.last) begin
                    state_nxt = RESP;
                    rdata_nxt = debug_in.data;
                    err_nxt   = 1'b0;
                end else begin
                    state_nxt = DROP;
                end
            end
            DROP: if (debug_in.valid && debug_in.last) state_nxt = RX_DEST;
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A response completing in the same cycle as the timeout takes precedence.
        if (timeout && state_nxt != RESP) begin
            state_nxt = RESP;
            rdata_nxt = '0;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            dest_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            cnt_q   <= in_rx ? cnt_q + CNT_W'(1) : '0;
            if (state == IDLE && bus.req_valid) begin
                dest_q  <= bus.req_dest;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
        end
    end

endmodule
